// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receive path.
//   PS2_CODE_EXT / PS2_CODE_BRK : prefix bytes folded into entry flags
//   ps2_state_e                 : frame deframer states
//   ps2_entry_t                 : queued scan code {ext, brk, code}
package ps2_pkg;

    localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK = 8'hF0;

    typedef enum logic {
        PS2_IDLE,
        PS2_DATA
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: generic first-word-fall-through FIFO (DEPTH power of two).
//   clk, resetn : system clock, synchronous active-low reset
//   wr_en       : write request; accepted when not full, or when full and
//                 a read happens in the same cycle
//   wr_data     : write word
//   rd_en       : read request; ignored while empty
//   rd_data     : head word, valid whenever empty=0
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
module ps2_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with scan-code FIFO.
// Synchronises the raw PS/2 lines, deframes 11-bit frames on falling ps2_clk
// edges, folds E0/F0 prefixes into flags and queues codes in a FWFT FIFO.
//   clk, resetn          : system clock, synchronous active-low reset
//   ps2_clk, ps2_data    : raw asynchronous PS/2 lines
//   out_data/ext/break   : head entry (zero while out_valid=0)
//   out_valid, out_ready : consumer handshake; pop when both high
//   frame_err            : one-cycle pulse on bad frame or timeout
//   overflow             : sticky, a code was dropped on a full FIFO
//   fifo_count           : current occupancy
// Build option: define PS2_RX_TIMEOUT_EN to enable the partial-frame watchdog
// (TIMEOUT_CYCLES); without it a partial frame waits indefinitely.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic [7:0]                   out_data,
    output logic                         out_ext,
    output logic                         out_break,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   prev_clk;
    logic                   strobe;
    logic                   timeout;

    ps2_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] shreg_q, shreg_d;
    logic [10:0] frame;
    logic        frame_ok;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        push_q, push_d;
    ps2_entry_t  entry_q, entry_d;
    logic        err_q, err_d;
    logic        overflow_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    ps2_entry_t  head;

    // Lines idle high, so the chains reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            prev_clk  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            prev_clk  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign strobe = prev_clk && !clk_s;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge clk) begin
        if (!resetn || strobe || cnt_q == '0) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign timeout = (cnt_q != '0) && !strobe && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Bits shift in from the top; after the stop bit arrives bit0 (start)
    // sits at frame[0] and the stop bit at frame[10].
    assign frame    = {data_s, shreg_q[10:1]};
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= PS2_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            push_q  <= 1'b0;
            entry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            push_q  <= push_d;
            entry_q <= entry_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        push_d  = 1'b0;
        entry_d = entry_q;
        err_d   = 1'b0;
        case (state_q)
            PS2_IDLE: begin
                if (strobe) begin
                    shreg_d = frame;
                    cnt_d   = 4'd1;
                    state_d = PS2_DATA;
                end
            end
            PS2_DATA: begin
                if (timeout) begin
                    state_d = PS2_IDLE;
                    cnt_d   = '0;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (strobe) begin
                    shreg_d = frame;
                    if (cnt_q == 4'd10) begin
                        cnt_d   = '0;
                        state_d = PS2_IDLE;
                        if (!frame_ok) begin
                            err_d = 1'b1;
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end else if (frame[8:1] == PS2_CODE_EXT) begin
                            ext_d = 1'b1;
                        end else if (frame[8:1] == PS2_CODE_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            push_d  = 1'b1;
                            entry_d = '{ext: ext_q, brk: brk_q, code: frame[8:1]};
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = PS2_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    ps2_sync_fifo #(
        .WIDTH ($bits(ps2_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push_q),
        .wr_data (entry_q),
        .rd_en   (out_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head.code : 8'h00;
    assign out_ext   = out_valid && head.ext;
    assign out_break = out_valid && head.brk;
    assign frame_err = err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: self-checking bench for ps2_rx_fifo. Frames are bit-banged
// on the PS/2 pins; expected FIFO contents, flags and error counts come from
// a queue-based model of the keyboard protocol.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_ext;
    logic       out_break;
    logic       out_valid;
    logic       frame_err;
    logic       overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_data   (out_data),
        .out_ext    (out_ext),
        .out_break  (out_break),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    int checks = 0;
    int failures = 0;
    int err_seen = 0;

    always @(negedge clk) if (frame_err) err_seen++;

    typedef struct {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ent_t;

    ent_t q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    logic m_ovf = 1'b0;
    int   m_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Odd parity: data bits plus parity bit XOR to 1.
    function automatic logic [10:0] mk(input logic [7:0] code, input bit good);
        logic par;
        par = good ? ~(^code) : (^code);
        return {1'b1, par, code, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] code, input bit good);
        ent_t e;
        if (!good) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e.ext = m_ext; e.brk = m_brk; e.code = code;
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] code, input bit good);
        logic [10:0] f;
        f = mk(code, good);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (SYNC + 4) @(negedge clk);
        model_frame(code, good);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        check({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_errs"}, 32'(err_seen), 32'(m_err));
        if (q.size() != 0) begin
            check({tag, "_data"}, 32'(out_data), 32'(q[0].code));
            check({tag, "_ext"}, 32'(out_ext), 32'(q[0].ext));
            check({tag, "_brk"}, 32'(out_break), 32'(q[0].brk));
        end else begin
            check({tag, "_data0"}, 32'(out_data), 32'h0);
            check({tag, "_flags0"}, 32'({out_ext, out_break}), 32'h0);
        end
    endtask

    task automatic pop_one(input string tag);
        check_state({tag, "_pre"});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state({tag, "_post"});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  c;
        int          lat;
        int          n;
        int          e0;
        int unsigned r;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_ext", 32'(out_ext), 32'h0);
        check("rst_brk", 32'(out_break), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check_state("post_rst");

        // 0x1C with latency measured from the stop-bit falling edge
        f = mk(8'h1C, 1'b1);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(SYNC + 2));
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        model_frame(8'h1C, 1'b1);
        pop_one("f1c");

        // E0 F0 75 folds into one entry
        send(8'hE0, 1'b1);
        check_state("e0");
        send(8'hF0, 1'b1);
        check_state("f0");
        send(8'h75, 1'b1);
        check_state("e0f0_75");
        pop_one("e0f0_75");

        // Bad parity, then good frame; bad frame also clears a pending prefix
        send(8'h1C, 1'b0);
        check_state("badpar");
        send(8'h32, 1'b1);
        pop_one("after_bad");
        send(8'hE0, 1'b1);
        send(8'h1C, 1'b0);
        send(8'h32, 1'b1);
        pop_one("prefix_cleared");

        // Fill, then push while popping on the same cycle
        for (int k = 0; k < DEPTH; k++) send(8'h10 + 8'(k), 1'b1);
        check_state("full");
        f = mk(8'h2A, 1'b1);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(q.pop_front());
        model_frame(8'h2A, 1'b1);
        check("pushpop_count", 32'(fifo_count), 32'(DEPTH));
        check("pushpop_ovf", 32'(overflow), 32'h0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        check_state("pushpop");

        // Overflow: dropped code, sticky flag, survivors in order
        send(8'h3B, 1'b1);
        check_state("ovf");
        while (q.size() != 0) pop_one("drain_ovf");
        check_state("ovf_sticky");

        // Reset in the middle of a frame with a pending prefix
        send(8'hE0, 1'b1);
        f = mk(8'h66, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        check_state("midrst");
        send(8'h1C, 1'b1);
        pop_one("after_midrst");

        // Randomised traffic with random draining
        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
            if (r == 0) send(8'hE0, 1'b1);
            else if (r == 1) send(8'hF0, 1'b1);
            else if (r == 2) send(c, 1'b0);
            else send(c, 1'b1);
            if ($urandom_range(0, 2) == 0) pop_one("rnd");
        end
        check_state("rnd_end");
        while (q.size() != 0) pop_one("rnd_drain");

`ifdef PS2_RX_TIMEOUT_EN
        // Partial frame aborted by the watchdog
        send(8'hE0, 1'b1);
        f = mk(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        e0 = err_seen;
        n = 0;
        for (int k = 1; k <= int'(TMO) + 60; k++) begin
            @(negedge clk);
            if (err_seen != e0) begin
                n = k;
                break;
            end
        end
        check("tmo_window", 32'(n >= int'(TMO) - 10 && n <= int'(TMO) + 10), 32'h1);
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_state("tmo");
        send(8'h1C, 1'b1);
        pop_one("after_tmo");
`else
        // Without the watchdog a stalled frame completes later
        f = mk(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        repeat (2 * TMO) @(negedge clk);
        check_state("stall");
        for (int i = 5; i < 11; i++) ps2_bit(f[i]);
        repeat (SYNC + 4) @(negedge clk);
        model_frame(8'h5A, 1'b1);
        pop_one("stall_done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
